// File: rtl/rcv_pkg.sv
// Shared types and constants for the receive-side frame controller.
// Optional feature macro: RCV_PARITY_EN (adds an even-parity bit after the data bits).
package rcv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    DATA,
    PARITY,
    STOP,
    LOAD
  } rcv_state_t;

  localparam int   RCV_DEFAULT_CLKS_PER_BIT = 10;
  localparam int   RCV_DEFAULT_DATA_BITS    = 8;
  localparam logic RCV_IDLE_LEVEL           = 1'b1;

endpackage

// File: rtl/rcv_frame_ctrl_if.sv
// Bus between the frame controller and its surroundings: raw line in,
// shift-register drive and readback, and the host-visible byte buffer.
interface rcv_frame_ctrl_if
  import rcv_pkg::*;
#(
  parameter int DATA_BITS = RCV_DEFAULT_DATA_BITS
);

  logic                 serial_in;
  logic [DATA_BITS-1:0] sr_data;
  logic                 data_read;
  logic                 sr_serial;
  logic                 shift_strobe;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 overrun_error;
  logic                 framing_error;
  logic                 parity_error;

  modport slave (
    input  serial_in, sr_data, data_read,
    output sr_serial, shift_strobe, rx_data, data_ready,
           overrun_error, framing_error, parity_error
  );

  modport master (
    output serial_in, sr_data, data_read,
    input  sr_serial, shift_strobe, rx_data, data_ready,
           overrun_error, framing_error, parity_error
  );

endinterface

// File: rtl/rcv_bit_timer.sv
// Bit-period down-counter with a one-cycle expire flag, plus the
// count of data bits already strobed in the current frame.
module rcv_bit_timer #(
  parameter int CNT_W = 8,
  parameter int BIT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  input  logic             bit_clr,
  input  logic             bit_inc,
  output logic             expire,
  output logic [BIT_W-1:0] bit_count
);

  logic [CNT_W-1:0] count;

  // Expiry is the last cycle of the loaded period; the counter then parks at 0.
  assign expire = enable && (count == CNT_W'(1));

  // Period counter and bit counter; a load always overrides counting down.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      bit_count <= '0;
    end else begin
      if (load) begin
        count <= load_value;
      end else if (enable && (count != '0)) begin
        count <= count - CNT_W'(1);
      end
      if (bit_clr) begin
        bit_count <= '0;
      end else if (bit_inc) begin
        bit_count <= bit_count + BIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rcv_frame_ctrl.sv
// Receive frame controller: synchronizes the line, finds start bits,
// strobes the downstream shift register mid-bit and buffers each good byte.
// Optional feature macro: RCV_PARITY_EN.
module rcv_frame_ctrl
  import rcv_pkg::*;
#(
  parameter int CLKS_PER_BIT = RCV_DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = RCV_DEFAULT_DATA_BITS
) (
  input  logic            clk,
  input  logic            rst,
  rcv_frame_ctrl_if.slave bus
);

  localparam int         BIT_W    = $clog2(DATA_BITS + 1);
  localparam logic [7:0] HALF_BIT = 8'(CLKS_PER_BIT / 2);
  localparam logic [7:0] FULL_BIT = 8'(CLKS_PER_BIT);

  rcv_state_t state, next_state;

  logic                 sync_1, line, line_prev, fall;
  logic                 timer_load, timer_en, expire, bit_clr, bit_inc;
  logic [7:0]           timer_value;
  logic [BIT_W-1:0]     bit_count;
  logic                 strobe, clear_flags, set_framing, do_load;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 data_ready_q, overrun_q, framing_q;
`ifdef RCV_PARITY_EN
  logic                 set_parity, parity_q;
`endif

  assign fall     = line_prev && !line;
  assign timer_en = (state == START_CHK) || (state == DATA) ||
                    (state == PARITY) || (state == STOP);

  rcv_bit_timer #(.CNT_W(8), .BIT_W(BIT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .enable     (timer_en),
    .bit_clr    (bit_clr),
    .bit_inc    (bit_inc),
    .expire     (expire),
    .bit_count  (bit_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Frame sequencing; strobe is combinational so it lands exactly on the expiry cycle.
  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = FULL_BIT;
    bit_clr     = 1'b0;
    bit_inc     = 1'b0;
    strobe      = 1'b0;
    clear_flags = 1'b0;
    set_framing = 1'b0;
    do_load     = 1'b0;
`ifdef RCV_PARITY_EN
    set_parity  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (fall) begin
          next_state  = START_CHK;
          timer_load  = 1'b1;
          timer_value = HALF_BIT;
          clear_flags = 1'b1;
        end
      end
      START_CHK: begin
        if (expire) begin
          if (line) begin
            next_state = IDLE;
          end else begin
            next_state = DATA;
            timer_load = 1'b1;
            bit_clr    = 1'b1;
          end
        end
      end
      DATA: begin
        if (expire) begin
          strobe     = 1'b1;
          bit_inc    = 1'b1;
          timer_load = 1'b1;
          if (bit_count == BIT_W'(DATA_BITS - 1)) begin
`ifdef RCV_PARITY_EN
            next_state = PARITY;
`else
            next_state = STOP;
`endif
          end
        end
      end
`ifdef RCV_PARITY_EN
      PARITY: begin
        if (expire) begin
          timer_load = 1'b1;
          next_state = STOP;
          set_parity = (^bus.sr_data) ^ line;
        end
      end
`endif
      STOP: begin
        if (expire) begin
          if (!line) begin
            set_framing = 1'b1;
            next_state  = IDLE;
          end else begin
`ifdef RCV_PARITY_EN
            next_state = parity_q ? IDLE : LOAD;
`else
            next_state = LOAD;
`endif
          end
        end
      end
      LOAD: begin
        do_load    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Line synchronizer, edge-detect history, host buffer and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1       <= RCV_IDLE_LEVEL;
      line         <= RCV_IDLE_LEVEL;
      line_prev    <= RCV_IDLE_LEVEL;
      rx_data_q    <= '1;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      framing_q    <= 1'b0;
`ifdef RCV_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      sync_1    <= bus.serial_in;
      line      <= sync_1;
      line_prev <= line;
      if (clear_flags) framing_q <= 1'b0;
      if (set_framing) framing_q <= 1'b1;
`ifdef RCV_PARITY_EN
      if (clear_flags) parity_q <= 1'b0;
      if (set_parity)  parity_q <= 1'b1;
`endif
      if (do_load) begin
        rx_data_q    <= bus.sr_data;
        data_ready_q <= 1'b1;
        if (bus.data_read)     overrun_q <= 1'b0;
        else if (data_ready_q) overrun_q <= 1'b1;
      end else if (bus.data_read) begin
        data_ready_q <= 1'b0;
        overrun_q    <= 1'b0;
      end
    end
  end

  assign bus.sr_serial     = line;
  assign bus.shift_strobe  = strobe;
  assign bus.rx_data       = rx_data_q;
  assign bus.data_ready    = data_ready_q;
  assign bus.overrun_error = overrun_q;
  assign bus.framing_error = framing_q;
`ifdef RCV_PARITY_EN
  assign bus.parity_error  = parity_q;
`else
  assign bus.parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_rcv_frame_ctrl.sv
// Directed bench for rcv_frame_ctrl, with a behavioural MSB-first shift
// register standing in for stp_sr_8_msb. Follows RCV_PARITY_EN if defined.
module tb_rcv_frame_ctrl;

  localparam int C  = 10;
  localparam int DB = 8;
`ifdef RCV_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME_SLOTS = DB + 2 + PBITS;
  // Offset from line fall to the LOAD cycle: 2 sync + half bit + data/parity/stop bits + 1.
  localparam int LOAD_OFF = 2 + C/2 + (DB + 1 + PBITS)*C + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DB-1:0] sr_model;
  int            cyc = 0;
  int            strobe_n = 0;
  int            strobe_cyc [16];
  int            frame_start = 0;
  int            total_checks = 0;
  int            bad_checks = 0;

  rcv_frame_ctrl_if #(.DATA_BITS(DB)) bus ();

  rcv_frame_ctrl #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle index: the cycle following posedge k carries cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream shift register model, MSB-first.
  always @(posedge clk) begin
    if (rst)                   sr_model <= '0;
    else if (bus.shift_strobe) sr_model <= {sr_model[DB-2:0], bus.sr_serial};
  end
  assign bus.sr_data = sr_model;

  // Record the cycle of every strobe.
  always @(negedge clk) begin
    if (bus.shift_strobe === 1'b1) begin
      if (strobe_n < 16) strobe_cyc[strobe_n] = cyc;
      strobe_n = strobe_n + 1;
    end
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks = total_checks + 1;
    if (got !== exp) begin
      bad_checks = bad_checks + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic driveLine(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      bus.serial_in = lvl;
      tick();
    end
  endtask

  task automatic pulseRead();
    bus.data_read = 1'b1;
    tick();
    bus.data_read = 1'b0;
  endtask

  // Sends one full frame; data_read is pulsed at offset read_at (-1 for never).
  task automatic applyStimulus(input logic [DB-1:0] data, input logic stop_bit,
                               input logic bad_par, input int read_at);
    int   slot;
    logic lvl;
    frame_start = cyc;
    strobe_n    = 0;
    for (int i = 0; i < FRAME_SLOTS*C; i++) begin
      slot = i / C;
      if (slot == 0)                              lvl = 1'b0;
      else if (slot <= DB)                        lvl = data[DB-slot];
      else if ((PBITS == 1) && (slot == DB + 1))  lvl = (^data) ^ bad_par;
      else                                        lvl = stop_bit;
      bus.serial_in = lvl;
      bus.data_read = (i == read_at);
      tick();
    end
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
  endtask

  initial begin
    bus.serial_in = 1'b0;
    bus.data_read = 1'b0;

    // Reset with the line held low.
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_sr_serial", 32'(bus.sr_serial), 32'h1);
    checkOutput("rst_rx_data", 32'(bus.rx_data), 32'hFF);
    checkOutput("rst_ready", 32'(bus.data_ready), 32'h0);
    checkOutput("rst_overrun", 32'(bus.overrun_error), 32'h0);
    checkOutput("rst_framing", 32'(bus.framing_error), 32'h0);
    checkOutput("rst_parity", 32'(bus.parity_error), 32'h0);
    checkOutput("rst_strobe", 32'(bus.shift_strobe), 32'h0);
    bus.serial_in = 1'b1;
    rst = 1'b0;
    driveLine(1'b1, 5);

    // Good frame A5 with strobe timing.
    applyStimulus(8'hA5, 1'b1, 1'b0, -1);
    checkOutput("a5_strobes", 32'(strobe_n), 32'd8);
    for (int k = 0; k < DB; k++)
      checkOutput($sformatf("a5_strobe%0d_ofs", k), 32'(strobe_cyc[k] - frame_start),
                  32'(2 + C/2 + (k+1)*C));
    checkOutput("a5_rx_data", 32'(bus.rx_data), 32'hA5);
    checkOutput("a5_ready", 32'(bus.data_ready), 32'h1);
    checkOutput("a5_framing", 32'(bus.framing_error), 32'h0);
    checkOutput("a5_overrun", 32'(bus.overrun_error), 32'h0);
    pulseRead();
    checkOutput("a5_read_ready", 32'(bus.data_ready), 32'h0);

    // Start glitch, 3 cycles low.
    strobe_n = 0;
    driveLine(1'b0, 3);
    driveLine(1'b1, 25);
    checkOutput("glitch_strobes", 32'(strobe_n), 32'd0);
    checkOutput("glitch_ready", 32'(bus.data_ready), 32'h0);
    checkOutput("glitch_rx_data", 32'(bus.rx_data), 32'hA5);
    checkOutput("glitch_framing", 32'(bus.framing_error), 32'h0);

    // Bad stop bit.
    applyStimulus(8'h3C, 1'b0, 1'b0, -1);
    checkOutput("badstop_framing", 32'(bus.framing_error), 32'h1);
    checkOutput("badstop_ready", 32'(bus.data_ready), 32'h0);
    checkOutput("badstop_rx_data", 32'(bus.rx_data), 32'hA5);
    driveLine(1'b1, 5);

    // Next good frame clears the framing flag.
    applyStimulus(8'h5A, 1'b1, 1'b0, -1);
    checkOutput("5a_framing", 32'(bus.framing_error), 32'h0);
    checkOutput("5a_rx_data", 32'(bus.rx_data), 32'h5A);
    checkOutput("5a_ready", 32'(bus.data_ready), 32'h1);
    checkOutput("5a_parity", 32'(bus.parity_error), 32'h0);
    pulseRead();

    // Overrun: back-to-back frames, no read.
    applyStimulus(8'h11, 1'b1, 1'b0, -1);
    applyStimulus(8'h22, 1'b1, 1'b0, -1);
    checkOutput("ovr_rx_data", 32'(bus.rx_data), 32'h22);
    checkOutput("ovr_flag", 32'(bus.overrun_error), 32'h1);
    checkOutput("ovr_ready", 32'(bus.data_ready), 32'h1);
    pulseRead();
    checkOutput("ovr_read_flag", 32'(bus.overrun_error), 32'h0);
    checkOutput("ovr_read_ready", 32'(bus.data_ready), 32'h0);

    // Read coinciding with the second LOAD: load wins, no overrun.
    applyStimulus(8'h11, 1'b1, 1'b0, -1);
    applyStimulus(8'h22, 1'b1, 1'b0, LOAD_OFF);
    checkOutput("coin_flag", 32'(bus.overrun_error), 32'h0);
    checkOutput("coin_ready", 32'(bus.data_ready), 32'h1);
    checkOutput("coin_rx_data", 32'(bus.rx_data), 32'h22);
    pulseRead();

    // Mid-frame reset after 4 strobes.
    frame_start = cyc;
    strobe_n    = 0;
    driveLine(1'b0, C);
    driveLine(1'b1, 4*C);
    checkOutput("mid_strobes_before", 32'(strobe_n), 32'd4);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("mid_rx_data", 32'(bus.rx_data), 32'hFF);
    checkOutput("mid_ready", 32'(bus.data_ready), 32'h0);
    driveLine(1'b1, 2*C);
    checkOutput("mid_strobes_after", 32'(strobe_n), 32'd4);
    applyStimulus(8'h0F, 1'b1, 1'b0, -1);
    checkOutput("0f_rx_data", 32'(bus.rx_data), 32'h0F);
    checkOutput("0f_ready", 32'(bus.data_ready), 32'h1);

`ifdef RCV_PARITY_EN
    // Wrong parity: flagged, byte discarded, ready untouched.
    driveLine(1'b1, 5);
    applyStimulus(8'h77, 1'b1, 1'b1, -1);
    checkOutput("par_flag", 32'(bus.parity_error), 32'h1);
    checkOutput("par_rx_data", 32'(bus.rx_data), 32'h0F);
    checkOutput("par_ready", 32'(bus.data_ready), 32'h1);
    applyStimulus(8'h81, 1'b1, 1'b0, -1);
    checkOutput("par_good_flag", 32'(bus.parity_error), 32'h0);
    checkOutput("par_good_rx_data", 32'(bus.rx_data), 32'h81);
`endif

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
